// File: rtl/mem_port_arbiter.sv
// Arbitrates the two data-memory ports between the MO pipeline stage and a DMA/loader master.
// MO has priority per port, with a starvation limit; DMA can lock a port for a bounded burst.
module mem_port_arbiter #(
    parameter int SIZE_ADDR    = 16,
    parameter int SIZE_DATA    = 32,
    parameter int P_STARVE_MAX = 4,
    parameter int P_BURST_MAX  = 8
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_pl_req,
    input  logic                 iw_pl_mp,
    input  logic                 iw_pl_we,
    input  logic [SIZE_ADDR-1:0] iw_pl_addr,
    input  logic [SIZE_DATA-1:0] iw_pl_wdata,
    output logic                 ow_pl_stall,
    output logic [SIZE_DATA-1:0] ow_pl_rdata,
    input  logic                 iw_dma_req,
    input  logic                 iw_dma_mp,
    input  logic                 iw_dma_we,
    input  logic [SIZE_ADDR-1:0] iw_dma_addr,
    input  logic [SIZE_DATA-1:0] iw_dma_wdata,
    input  logic                 iw_dma_last,
    output logic                 ow_dma_gnt,
    output logic                 ow_dma_rvalid,
    output logic [SIZE_DATA-1:0] ow_dma_rdata,
    output logic                 ow_mem0_en,
    output logic                 ow_mem0_we,
    output logic [SIZE_ADDR-1:0] ow_mem0_addr,
    output logic [SIZE_DATA-1:0] ow_mem0_wdata,
    input  logic [SIZE_DATA-1:0] iw_mem0_rdata,
    output logic                 ow_mem1_en,
    output logic                 ow_mem1_we,
    output logic [SIZE_ADDR-1:0] ow_mem1_addr,
    output logic [SIZE_DATA-1:0] ow_mem1_wdata,
    input  logic [SIZE_DATA-1:0] iw_mem1_rdata
);

    typedef enum logic {S_OPEN, S_LOCK} state_t;

    logic [1:0]           pl_hit, dma_hit, mo_win, dma_win;
    logic                 m_en    [2];
    logic                 m_we    [2];
    logic [SIZE_ADDR-1:0] m_addr  [2];
    logic [SIZE_DATA-1:0] m_wdata [2];
    logic [SIZE_DATA-1:0] mem_rdata [2];

    for (genvar p = 0; p < 2; p++) begin : g_port
        state_t     st;
        logic [3:0] starve_cnt;
        logic [7:0] beat_cnt;
        logic       mo_w, dma_w;

        assign pl_hit[p]  = iw_pl_req  && (iw_pl_mp  == 1'(p));
        assign dma_hit[p] = iw_dma_req && (iw_dma_mp == 1'(p));

        always_comb begin
            mo_w  = 1'b0;
            dma_w = 1'b0;
            if (st == S_LOCK) begin
                dma_w = dma_hit[p];
            end else if (pl_hit[p] && dma_hit[p]) begin
                dma_w = (starve_cnt == 4'(P_STARVE_MAX));
                mo_w  = !dma_w;
            end else begin
                mo_w  = pl_hit[p];
                dma_w = dma_hit[p];
            end
        end

        assign mo_win[p]  = mo_w;
        assign dma_win[p] = dma_w;
        assign m_en[p]    = mo_w | dma_w;
        assign m_we[p]    = mo_w ? iw_pl_we    : (dma_w ? iw_dma_we    : 1'b0);
        assign m_addr[p]  = mo_w ? iw_pl_addr  : (dma_w ? iw_dma_addr  : '0);
        assign m_wdata[p] = mo_w ? iw_pl_wdata : (dma_w ? iw_dma_wdata : '0);

        always_ff @(posedge iw_clk or posedge iw_rst) begin
            if (iw_rst) begin
                st         <= S_OPEN;
                starve_cnt <= '0;
                beat_cnt   <= '0;
            end else begin
                if (dma_w || !dma_hit[p])
                    starve_cnt <= '0;
                else if (mo_w)
                    starve_cnt <= starve_cnt + 4'd1;

                case (st)
                    S_OPEN: begin
                        // A single-beat limit never holds a lock past its first beat.
                        if (dma_w && !iw_dma_last && P_BURST_MAX > 1) begin
                            st       <= S_LOCK;
                            beat_cnt <= 8'd1;
                        end
                    end
                    default: begin
                        // In a lock a present DMA request is always granted, so dma_hit marks a beat.
                        if (!dma_hit[p] || iw_dma_last || beat_cnt == 8'(P_BURST_MAX - 1)) begin
                            st       <= S_OPEN;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ow_pl_stall = iw_pl_req && !mo_win[iw_pl_mp];
    assign ow_dma_gnt  = dma_win[iw_dma_mp];

    assign ow_mem0_en    = m_en[0];
    assign ow_mem0_we    = m_we[0];
    assign ow_mem0_addr  = m_addr[0];
    assign ow_mem0_wdata = m_wdata[0];
    assign ow_mem1_en    = m_en[1];
    assign ow_mem1_we    = m_we[1];
    assign ow_mem1_addr  = m_addr[1];
    assign ow_mem1_wdata = m_wdata[1];

    assign mem_rdata[0] = iw_mem0_rdata;
    assign mem_rdata[1] = iw_mem1_rdata;

    logic                 dma_pend, dma_mp_q, pl_pend, pl_mp_q;
    logic [SIZE_DATA-1:0] pl_rdata_q;

    // Memory data arrives the cycle after the grant, so the return path muxes it live
    // and only the MO side keeps a copy to hold between reads.
    assign ow_dma_rvalid = dma_pend;
    assign ow_dma_rdata  = dma_pend ? mem_rdata[dma_mp_q] : '0;
    assign ow_pl_rdata   = pl_pend  ? mem_rdata[pl_mp_q]  : pl_rdata_q;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            dma_pend   <= 1'b0;
            dma_mp_q   <= 1'b0;
            pl_pend    <= 1'b0;
            pl_mp_q    <= 1'b0;
            pl_rdata_q <= '0;
        end else begin
            dma_pend <= ow_dma_gnt && !iw_dma_we;
            dma_mp_q <= iw_dma_mp;
            pl_pend  <= iw_pl_req && !ow_pl_stall && !iw_pl_we;
            pl_mp_q  <= iw_pl_mp;
            if (pl_pend)
                pl_rdata_q <= mem_rdata[pl_mp_q];
        end
    end

endmodule
